binary2gray: RTL and testbench

BINARY2GRAY -- requirements
Module: binary2gray

---
 rtl/binary2gray_if.sv | 12 +
 rtl/binary2gray.sv | 79 +++++++
 tb/tb_binary2gray.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/binary2gray_if.sv
// Pixel stream bundle for binary2gray: binary pixel in, gray level out.
interface binary2gray_if;
  logic        iDVAL;
  logic [11:0] iDATA;
  logic        oDVAL;
  logic [11:0] oDATA;

  // source of pixels / sink of gray levels
  modport master (output iDVAL, output iDATA, input oDVAL, input oDATA);
  // the converter itself
  modport slave  (input iDVAL, input iDATA, output oDVAL, output oDATA);
endinterface

// File: rtl/binary2gray.sv
// Binary-to-gray reconstruction: counts white samples over a sliding window
// of the last WIN pixels and scales that count to a 12-bit gray level.
// Two-stage pipeline, one pixel per cycle, window cleared after a line gap.
module binary2gray #(
  parameter int WIN_LOG2 = 4,
  parameter int LINE_GAP = 16
) (
  input  logic iCLK,
  input  logic iRST,
  binary2gray_if.slave bus
);
  localparam int WIN = 1 << WIN_LOG2;
  localparam int SW  = WIN_LOG2 + 1;
  localparam int GW  = $clog2(LINE_GAP + 1);

  logic [WIN-1:0] window;
  logic [SW-1:0]  sum;
  logic [GW-1:0]  gap;
  logic           vld1;

  logic           pix;
  logic [WIN:0]   ext;
  logic [GW-1:0]  gap_inc;
  logic           line_clr;
  logic [11:0]    level;
  logic           unused_bits;

  // only the MSB carries the black/white decision
  assign pix         = bus.iDATA[11];
  assign unused_bits = ^bus.iDATA[10:0];

  // newest sample enters at bit 0; bit WIN-1 is the one falling out
  assign ext = {window, pix};

  // gap counter saturates, so the clear keeps firing while the gap lasts;
  // a valid pixel always wins over the clear
  assign gap_inc  = (gap == GW'(LINE_GAP)) ? gap : gap + 1'b1;
  assign line_clr = !bus.iDVAL && (gap_inc == GW'(LINE_GAP));

  // full window would scale to 4096, which does not fit in 12 bits
  always_comb begin
    level = 12'(sum) << (12 - WIN_LOG2);
    if (sum == SW'(WIN)) level = 12'hFFF;
  end

  // stage 1: window shift, running white count, line-gap tracking
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      window <= '0;
      sum    <= '0;
      gap    <= '0;
      vld1   <= 1'b0;
    end else begin
      vld1 <= bus.iDVAL;
      if (bus.iDVAL) begin
        window <= ext[WIN-1:0];
        sum    <= sum + SW'(pix) - SW'(window[WIN-1]);
        gap    <= '0;
      end else begin
        gap <= gap_inc;
        if (line_clr) begin
          window <= '0;
          sum    <= '0;
        end
      end
    end
  end

  // stage 2: scale count to gray level; output holds between valid pixels
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bus.oDVAL <= 1'b0;
      bus.oDATA <= '0;
    end else begin
      bus.oDVAL <= vld1;
      if (vld1) bus.oDATA <= level;
    end
  end
endmodule

// File: tb/tb_binary2gray.sv
// Bench for binary2gray: a per-line pixel-history model predicts every output
// cycle; directed sequences with literal expectations pin the model.
module tb_binary2gray;
  localparam int WIN_LOG2 = 4;
  localparam int LINE_GAP = 16;
  localparam int WIN      = 1 << WIN_LOG2;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  binary2gray_if bus ();

  binary2gray #(.WIN_LOG2(WIN_LOG2), .LINE_GAP(LINE_GAP)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus.slave)
  );

  always #5 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;

  // model state: pixels of the current line (newest last), idle run length
  int   hist[$];
  int   idle = 0;
  bit   started = 0;
  logic m_v1 = 0, m_ov = 0;
  int   m_d1 = 0, m_od = 0;
  int   outq[$];

  function automatic int gray_of(input int whites);
    if (whites == WIN) return 4095;
    return whites * (4096 / WIN);
  endfunction

  // model: line history, gap-driven clear, two-cycle pipeline delay
  always @(posedge iCLK) begin
    if (iRST) begin
      hist.delete();
      idle = 0; m_v1 = 0; m_ov = 0; m_d1 = 0; m_od = 0;
      started = 1;
    end else begin
      int w;
      m_ov = m_v1;
      if (m_v1) m_od = m_d1;
      m_v1 = bus.iDVAL;
      if (bus.iDVAL === 1'b1) begin
        hist.push_back(bus.iDATA[11] ? 1 : 0);
        while (hist.size() > WIN) void'(hist.pop_front());
        idle = 0;
        w = 0;
        foreach (hist[i]) w += hist[i];
        m_d1 = gray_of(w);
      end else begin
        idle++;
        if (idle >= LINE_GAP) hist.delete();
      end
    end
  end

  // compare every cycle once reset has been seen; collect valid outputs
  always @(negedge iCLK) begin
    if (started) begin
      total++;
      if (bus.oDVAL !== m_ov || bus.oDATA !== int'(m_od)) begin
        bad++;
        $display("FAIL cycle_compare t=%0t got dval=%b data=%0d want dval=%b data=%0d",
                 $time, bus.oDVAL, bus.oDATA, m_ov, m_od);
      end
      if (bus.oDVAL === 1'b1) outq.push_back(int'(bus.oDATA));
    end
  end

  task automatic check_lit(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic q_at(input string name, input int idx, input int want);
    if (idx < outq.size()) check_lit(name, outq[idx], want);
    else check_lit({name, "_missing"}, -1, want);
  endtask

  // one clock: apply inputs, return 1 time unit after the edge
  task automatic step(input logic v, input logic w, input logic r);
    iRST      = r;
    bus.iDVAL = v;
    bus.iDATA = w ? 12'hFFF : 12'h000;
    @(posedge iCLK);
    #1;
  endtask

  task automatic pixels(input logic w, input int n);
    for (int i = 0; i < n; i++) step(1'b1, w, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    iRST = 1'b0;
    outq.delete();
  endtask

  initial begin
    bus.iDVAL = 1'b0;
    bus.iDATA = '0;

    // reset state
    do_reset();
    check_lit("reset_odval", int'(bus.oDVAL), 0);
    check_lit("reset_odata", int'(bus.oDATA), 0);

    // 16 whites ramp up to saturation
    pixels(1'b1, 16);
    check_lit("ramp_first_latency", int'(bus.oDVAL), 1);
    gap(2);
    check_lit("ramp_count", outq.size(), 16);
    q_at("ramp_0", 0, 256);
    q_at("ramp_7", 7, 2048);
    q_at("ramp_14", 14, 3840);
    q_at("ramp_15", 15, 4095);

    // 16 blacks ramp down (short gap does not clear)
    outq.delete();
    pixels(1'b0, 16);
    gap(2);
    q_at("fall_0", 0, 3840);
    q_at("fall_14", 14, 256);
    q_at("fall_15", 15, 0);
    check_lit("hold_after_line", int'(bus.oDATA), 0);

    // alternating white/black from reset
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, (i % 2 == 0), 1'b0);
    gap(2);
    q_at("alt_0", 0, 256);
    q_at("alt_2", 2, 512);
    q_at("alt_15", 15, 2048);
    q_at("alt_31", 31, 2048);

    // 15-cycle gap keeps the window; 16-cycle gap clears it
    do_reset();
    pixels(1'b1, 16);
    gap(15);
    pixels(1'b1, 1);
    gap(16);
    pixels(1'b1, 1);
    gap(2);
    check_lit("gap_count", outq.size(), 18);
    q_at("gap15_keep", 16, 4095);
    q_at("gap16_clear", 17, 256);
    check_lit("gap_hold", int'(bus.oDATA), 256);

    // reset pulse in the middle of a white run discards in-flight pixels
    do_reset();
    pixels(1'b1, 5);
    step(1'b1, 1'b1, 1'b1);
    outq.delete();
    check_lit("midrst_odval0", int'(bus.oDVAL), 0);
    gap(1);
    check_lit("midrst_odval1", int'(bus.oDVAL), 0);
    pixels(1'b1, 1);
    gap(2);
    check_lit("midrst_count", outq.size(), 1);
    q_at("midrst_first", 0, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
